// File: rtl/irq_request_controller.sv
// Four-source interrupt front end with edge capture and sticky overrun flags.
// Presents the highest-index enabled pending source through a valid/ack handshake.
module irq_request_controller #(
    parameter int N_SRC = 4,
    parameter int VEC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_in,
    input  logic [N_SRC-1:0] mask,
    input  logic             irq_ack,
    input  logic             eoi,
    output logic             irq_valid,
    output logic [VEC_W-1:0] irq_vec,
    output logic             in_service,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] overrun
);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        SERVICE
    } state_t;

    state_t           state;
    logic [N_SRC-1:0] src_prev;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] clr;
    logic [VEC_W-1:0] winner;

    always_comb begin
        rise     = src_in & ~src_prev;
        eligible = pending & mask;
        winner   = '0;
        // ascending scan, so the highest set index is the last one written
        for (int i = 0; i < N_SRC; i++) begin
            if (eligible[i]) winner = VEC_W'(i);
        end
        clr = '0;
        if (state == PRESENT && irq_ack) clr[irq_vec] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            src_prev <= '0;
            pending  <= '0;
            overrun  <= '0;
            irq_vec  <= '0;
        end else begin
            src_prev <= src_in;
            // a new edge beats the acceptance clear of the same bit
            pending  <= rise | (pending & ~clr);
            overrun  <= overrun | (rise & pending & ~clr);
            unique case (state)
                IDLE: begin
                    if (|eligible) begin
                        irq_vec <= winner;
                        state   <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (irq_ack) state <= SERVICE;
                end
                SERVICE: begin
                    if (eoi) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign irq_valid  = (state == PRESENT);
    assign in_service = (state == SERVICE);

endmodule

// File: tb/tb_irq_request_controller.sv
// Bench for irq_request_controller: directed vector table plus random traffic
// compared against an event-level reference model.
module tb_irq_request_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src_in;
    logic [3:0] mask;
    logic       irq_ack;
    logic       eoi;
    logic       irq_valid;
    logic [1:0] irq_vec;
    logic       in_service;
    logic [3:0] pending;
    logic [3:0] overrun;

    irq_request_controller #(.N_SRC(4), .VEC_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_in     (src_in),
        .mask       (mask),
        .irq_ack    (irq_ack),
        .eoi        (eoi),
        .irq_valid  (irq_valid),
        .irq_vec    (irq_vec),
        .in_service (in_service),
        .pending    (pending),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [7:0] act,
                         input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Reference model: phase 0 waiting, 1 offering, 2 servicing.
    int m_phase;
    int m_vec;
    bit m_pend[4];
    bit m_ovr[4];
    bit m_prev[4];

    function automatic logic [3:0] pack(input bit a[4]);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = a[i];
        return r;
    endfunction

    task automatic model_step();
        int best;
        int taken;
        bit ev;
        if (rst) begin
            m_phase = 0;
            m_vec   = 0;
            for (int i = 0; i < 4; i++) begin
                m_pend[i] = 0;
                m_ovr[i]  = 0;
                m_prev[i] = 0;
            end
            return;
        end
        best = -1;
        for (int i = 0; i < 4; i++)
            if (m_pend[i] && mask[i]) best = i;
        taken = (m_phase == 1 && irq_ack) ? m_vec : -1;
        for (int i = 0; i < 4; i++) begin
            ev = src_in[i] && !m_prev[i];
            if (ev && m_pend[i] && taken != i) m_ovr[i] = 1;
            if (ev) m_pend[i] = 1;
            else if (taken == i) m_pend[i] = 0;
            m_prev[i] = src_in[i];
        end
        case (m_phase)
            0: if (best >= 0) begin
                   m_vec   = best;
                   m_phase = 1;
               end
            1: if (irq_ack) m_phase = 2;
            default: if (eoi) m_phase = 0;
        endcase
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("mdl_valid", 8'(irq_valid), 8'(m_phase == 1));
        check("mdl_insvc", 8'(in_service), 8'(m_phase == 2));
        check("mdl_pend", 8'(pending), 8'(pack(m_pend)));
        check("mdl_ovr", 8'(overrun), 8'(pack(m_ovr)));
        if (m_phase == 1) check("mdl_vec", 8'(irq_vec), 8'(m_vec));
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] src;
        logic [3:0] mask;
        logic       ack;
        logic       eoi;
        logic       valid;
        logic [1:0] vec;
        logic       insvc;
        logic [3:0] pend;
        logic [3:0] ovr;
    } row_t;

    row_t tbl[$];

    function automatic row_t mk(input logic r, input logic [3:0] s,
                                input logic [3:0] m, input logic a,
                                input logic e, input logic v,
                                input logic [1:0] vc, input logic sv,
                                input logic [3:0] p, input logic [3:0] o);
        row_t x;
        x.rst = r; x.src = s; x.mask = m; x.ack = a; x.eoi = e;
        x.valid = v; x.vec = vc; x.insvc = sv; x.pend = p; x.ovr = o;
        return x;
    endfunction

    initial begin
        rst = 1'b1; src_in = '0; mask = 4'hF; irq_ack = 0; eoi = 0;
        // single pulse on src 1
        tbl.push_back(mk(1, 4'b0000, 4'hF, 0, 0, 0, 2'd0, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 0, 0, 0, 2'd0, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 4'b0010, 4'hF, 0, 0, 0, 2'd0, 0, 4'b0010, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 0, 0, 1, 2'd1, 0, 4'b0010, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 1, 0, 0, 2'd1, 1, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 0, 1, 0, 2'd1, 0, 4'b0000, 4'b0000));
        // simultaneous src 0 and 2
        tbl.push_back(mk(0, 4'b0101, 4'hF, 0, 0, 0, 2'd1, 0, 4'b0101, 4'b0000));
        tbl.push_back(mk(0, 4'b0101, 4'hF, 0, 0, 1, 2'd2, 0, 4'b0101, 4'b0000));
        tbl.push_back(mk(0, 4'b0101, 4'hF, 1, 0, 0, 2'd2, 1, 4'b0001, 4'b0000));
        tbl.push_back(mk(0, 4'b0101, 4'hF, 0, 1, 0, 2'd2, 0, 4'b0001, 4'b0000));
        tbl.push_back(mk(0, 4'b0101, 4'hF, 0, 0, 1, 2'd0, 0, 4'b0001, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 1, 0, 0, 2'd0, 1, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 0, 1, 0, 2'd0, 0, 4'b0000, 4'b0000));
        // vector held while a higher source arrives
        tbl.push_back(mk(0, 4'b0010, 4'hF, 0, 0, 0, 2'd0, 0, 4'b0010, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 0, 0, 1, 2'd1, 0, 4'b0010, 4'b0000));
        tbl.push_back(mk(0, 4'b1000, 4'hF, 0, 0, 1, 2'd1, 0, 4'b1010, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 1, 0, 0, 2'd1, 1, 4'b1000, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 0, 1, 0, 2'd1, 0, 4'b1000, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 0, 0, 1, 2'd3, 0, 4'b1000, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 1, 0, 0, 2'd3, 1, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 0, 1, 0, 2'd3, 0, 4'b0000, 4'b0000));
        // masked source pends but is not offered
        tbl.push_back(mk(0, 4'b1000, 4'h7, 0, 0, 0, 2'd3, 0, 4'b1000, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'h7, 0, 0, 0, 2'd3, 0, 4'b1000, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'h7, 0, 0, 0, 2'd3, 0, 4'b1000, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 0, 0, 1, 2'd3, 0, 4'b1000, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 1, 0, 0, 2'd3, 1, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 0, 1, 0, 2'd3, 0, 4'b0000, 4'b0000));
        // overrun, then rise on the cycle it is acked
        tbl.push_back(mk(0, 4'b0100, 4'hF, 0, 0, 0, 2'd3, 0, 4'b0100, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 0, 0, 1, 2'd2, 0, 4'b0100, 4'b0000));
        tbl.push_back(mk(0, 4'b0100, 4'hF, 0, 0, 1, 2'd2, 0, 4'b0100, 4'b0100));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 0, 0, 1, 2'd2, 0, 4'b0100, 4'b0100));
        tbl.push_back(mk(0, 4'b0100, 4'hF, 1, 0, 0, 2'd2, 1, 4'b0100, 4'b0100));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 0, 1, 0, 2'd2, 0, 4'b0100, 4'b0100));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 0, 0, 1, 2'd2, 0, 4'b0100, 4'b0100));
        // eoi ignored while offering; ack+eoi only acks; ack ignored in service
        tbl.push_back(mk(0, 4'b0000, 4'hF, 0, 1, 1, 2'd2, 0, 4'b0100, 4'b0100));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 1, 1, 0, 2'd2, 1, 4'b0000, 4'b0100));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 1, 0, 0, 2'd2, 1, 4'b0000, 4'b0100));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 0, 1, 0, 2'd2, 0, 4'b0000, 4'b0100));
        // reset in service with pending 1010, src 3 held through reset
        tbl.push_back(mk(0, 4'b1010, 4'hF, 0, 0, 0, 2'd2, 0, 4'b1010, 4'b0100));
        tbl.push_back(mk(0, 4'b0000, 4'hF, 0, 0, 1, 2'd3, 0, 4'b1010, 4'b0100));
        tbl.push_back(mk(0, 4'b1000, 4'hF, 1, 0, 0, 2'd3, 1, 4'b1010, 4'b0100));
        tbl.push_back(mk(1, 4'b1000, 4'hF, 0, 0, 0, 2'd0, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 4'b1000, 4'hF, 0, 0, 0, 2'd0, 0, 4'b1000, 4'b0000));
        tbl.push_back(mk(0, 4'b1000, 4'hF, 0, 0, 1, 2'd3, 0, 4'b1000, 4'b0000));
        tbl.push_back(mk(0, 4'b1000, 4'hF, 1, 0, 0, 2'd3, 1, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 4'b1000, 4'hF, 0, 1, 0, 2'd3, 0, 4'b0000, 4'b0000));

        foreach (tbl[k]) begin
            rst = tbl[k].rst; src_in = tbl[k].src; mask = tbl[k].mask;
            irq_ack = tbl[k].ack; eoi = tbl[k].eoi;
            tick();
            check($sformatf("row%0d_valid", k), 8'(irq_valid), 8'(tbl[k].valid));
            check($sformatf("row%0d_vec", k), 8'(irq_vec), 8'(tbl[k].vec));
            check($sformatf("row%0d_insvc", k), 8'(in_service), 8'(tbl[k].insvc));
            check($sformatf("row%0d_pend", k), 8'(pending), 8'(tbl[k].pend));
            check($sformatf("row%0d_ovr", k), 8'(overrun), 8'(tbl[k].ovr));
        end

        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 99) == 0);
            src_in  = 4'($urandom);
            mask    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            irq_ack = ($urandom_range(0, 2) == 0);
            eoi     = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_request_controller.md
Name: irq_request_controller

Overview:
- Sequential front end for a 4-source interrupt path.
- Edge-detects raw request lines, holds them as pending events, and applies an enable mask.
- Selects the highest-index enabled pending source and presents its index as a vector with a valid/ack handshake.
- Tracks in-service status until end-of-interrupt; counts nothing, but flags lost events per source.

Parameters:
N_SRC, 4, number of request sources (design and test at 4)
VEC_W, 2, vector width; must equal clog2(N_SRC)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
src_in  input  N_SRC  raw level request lines, already synchronous to clk
mask  input  N_SRC  per-source enable, 1 = enabled
irq_ack  input  1  consumer accepts presented vector (ready)
eoi  input  1  end-of-interrupt pulse from consumer
irq_valid  output  1  vector presented
irq_vec  output  VEC_W  index of presented source
in_service  output  1  accepted interrupt being serviced
pending  output  N_SRC  registered pending events
overrun  output  N_SRC  sticky lost-event flags

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; pending, overrun, irq_vec, irq_valid, in_service, src_prev all 0.
  - Because src_prev resets to 0, a source held high through reset release registers one event.
- Edge detect:
  - rise[i] = src_in[i] & ~src_prev[i]; src_prev <= src_in every cycle.
  - Level-held inputs produce exactly one event.
- Pending:
  - On rise[i]: pending[i] <= 1.
  - If pending[i] is already 1 and not being cleared this cycle, set overrun[i] <= 1. overrun is sticky until rst.
  - pending[i] clears only on acceptance of vector i.
  - Same-cycle rise[i] and clear of bit i: set wins, pending[i] stays 1, no overrun.
  - Masked sources still set pending; the mask gates selection only.
- Selection: eligible = pending & mask. The highest set index wins (3 > 2 > 1 > 0), and the vector equals the index (src 1 -> 2'b01, src 0 -> 2'b00).
- FSM states IDLE, PRESENT, SERVICE:
  - IDLE: if eligible != 0, then irq_vec <= winner and go to PRESENT; otherwise stay.
  - PRESENT: irq_valid=1.
    - irq_vec is held stable; it is not re-arbitrated even if a higher source arrives or the mask changes.
    - On irq_ack=1: clear pending[irq_vec] and go to SERVICE.
  - SERVICE: in_service=1, irq_valid=0. On eoi=1, go to IDLE.
- irq_valid and in_service are decoded from registered state, so they are glitch-free and mutually exclusive.
- Latency:
  - Rising src_in sampled at edge k -> pending set after k -> PRESENT and irq_valid=1 after edge k+1.
  - ack at edge m -> in_service=1 after m.
  - eoi at edge n -> IDLE after n; a waiting eligible source gives irq_valid=1 after n+1.
- Ignored inputs: irq_ack outside PRESENT, and eoi outside SERVICE.
- Simultaneous irq_ack and eoi in PRESENT: only the ack acts.
- rst mid-operation: immediate return to the reset values above. Pending events are lost, and overrun is cleared.

Test Plan:
- Reset release with src_in=4'b0000, mask=4'b1111: all outputs 0. Then pulse src_in[1] for one cycle -> pending=4'b0010, irq_valid=1 two edges later, irq_vec=2'b01.
- src_in 0->4'b0101 in the same cycle -> irq_vec=2'b10. Ack -> pending=4'b0001, in_service=1. eoi -> irq_vec=2'b00, irq_valid=1 one cycle after IDLE.
- Priority hold: in PRESENT with vec=2'b01, raise src_in[3] -> irq_vec stays 2'b01. After ack+eoi, next vector is 2'b11.
- Mask: mask=4'b0111 with event on src 3 -> irq_valid stays 0 and pending[3]=1. Set mask=4'b1111 -> irq_valid=1, vec=2'b11.
- Overrun and set-wins:
  - Two separate rising edges on src 2 before ack -> overrun=4'b0100, pending[2]=1.
  - Rise on src 2 in the same cycle it is acked -> pending[2] remains 1, overrun unchanged.
- Reset mid-operation: in SERVICE with pending=4'b1010, assert rst one cycle -> all outputs 0. src_in held at 4'b1000 through reset -> a new event gives vec=2'b11.
